// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ksa_pkg
// Purpose : Shared definitions for the shared iterative Kogge-Stone adder:
//           controller state encoding, requester count, parameter defaults
//           and a helper that sizes the prefix-level counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ksa_pkg;

  localparam int NREQ     = 2;
  localparam int W_DEF    = 32;
  localparam int CNTW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LVL  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of a counter that indexes 0..levels-1; never narrower than 1 bit.
  function automatic int k_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_level_step.sv
`default_nettype none
// ============================================================================
// Module  : ksa_level_step
// Purpose : One Kogge-Stone prefix level, purely combinational. Every level's
//           combine network is built side by side and the level index k
//           selects which one drives the outputs, so a single step module
//           serves all LOG2W levels of the iteration.
// Ports   : p_i, g_i  - working propagate / generate vectors
//           k_i       - level index; combine distance is 2**k_i
//           p_o, g_o  - vectors after this level
// Revision: 1.0 - initial release
// ============================================================================
module ksa_level_step
  import ksa_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LOG2W = $clog2(W),
  parameter int KW    = k_width(LOG2W)
) (
  input  logic [W-1:0]  p_i,
  input  logic [W-1:0]  g_i,
  input  logic [KW-1:0] k_i,
  output logic [W-1:0]  p_o,
  output logic [W-1:0]  g_o
);

  logic [W-1:0] w_p_lvl [LOG2W];
  logic [W-1:0] w_g_lvl [LOG2W];

  for (genvar l = 0; l < LOG2W; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_black
        // Black cell: merge this group with the group D bits below.
        assign w_g_lvl[l][i] = g_i[i] | (p_i[i] & g_i[i-D]);
        assign w_p_lvl[l][i] = p_i[i] & p_i[i-D];
      end else begin : g_buf
        // Nothing D bits below: the group is already complete, pass through.
        assign w_g_lvl[l][i] = g_i[i];
        assign w_p_lvl[l][i] = p_i[i];
      end
    end
  end

  always_comb begin
    p_o = p_i;
    g_o = g_i;
    for (int l = 0; l < LOG2W; l++) begin
      if (k_i == KW'(l)) begin
        p_o = w_p_lvl[l];
        g_o = w_g_lvl[l];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ksa_share_sched.sv
`default_nettype none
// ============================================================================
// Module  : ksa_share_sched
// Purpose : Iterative Kogge-Stone adder shared by two requesters. A
//           round-robin arbiter grants one request in IDLE, the prefix tree
//           is evaluated one level per clock, and the result is returned on
//           a valid/ready channel tagged with the requester id.
// Ports   : clk, rst_n             - clock, async active-low reset
//           req_valid/req_ready    - per-requester handshake (2 bits)
//           req_a, req_b, req_cin  - operands, requester i at [i*W +: W]
//           rsp_valid/rsp_ready    - result handshake
//           rsp_id, rsp_sum,
//           rsp_cout               - result owner and A+B+cin
//           busy                   - controller not in IDLE
//           done_cnt               - completed responses, wrapping
// Revision: 1.0 - initial release
// ============================================================================
module ksa_share_sched
  import ksa_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LOG2W = $clog2(W),
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ-1:0]     req_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_cout,
  output logic                busy,
  output logic [CNTW-1:0]     done_cnt
);

  localparam int            KW     = k_width(LOG2W);
  localparam logic [KW-1:0] K_LAST = KW'(LOG2W - 1);

  state_e          state_q, state_d;
  logic            rr_last_q;
  logic            id_q;
  logic [W-1:0]    p0_q;
  logic [W-1:0]    p_q;
  logic [W-1:0]    g_q;
  logic            cin_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic [CNTW-1:0] done_cnt_q;

  logic            w_grant;
  logic            w_accept;
  logic            w_rsp_fire;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_cin;
  logic [W-1:0]    w_p_init;
  logic [W-1:0]    w_g_init;
  logic [W-1:0]    w_p_next;
  logic [W-1:0]    w_g_next;

  // --------------------------------------------------------------------------
  // Arbitration and operand selection
  // --------------------------------------------------------------------------
  // With both pending, the requester not served last wins; otherwise the
  // lone pending requester (bit 1 if it is the one set) is granted.
  assign w_grant    = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
  assign w_accept   = (state_q == IDLE) && (|req_valid);
  assign w_rsp_fire = (state_q == RESP) && rsp_ready;

  assign w_a   = w_grant ? req_a[2*W-1:W] : req_a[W-1:0];
  assign w_b   = w_grant ? req_b[2*W-1:W] : req_b[W-1:0];
  assign w_cin = w_grant ? req_cin[1]     : req_cin[0];

  // Folding cin into bit 0's generate makes every prefix g[i] the carry out
  // of bit i including cin, so no extra carry-in handling is needed later.
  assign w_p_init = w_a ^ w_b;
  assign w_g_init = {w_a[W-1:1] & w_b[W-1:1],
                     (w_a[0] & w_b[0]) | (w_p_init[0] & w_cin)};

  ksa_level_step #(
    .W     (W),
    .LOG2W (LOG2W),
    .KW    (KW)
  ) u_step (
    .p_i (p_q),
    .g_i (g_q),
    .k_i (k_q),
    .p_o (w_p_next),
    .g_o (w_g_next)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept)        state_d = LVL;
      LVL:     if (k_q == K_LAST)   state_d = RESP;
      RESP:    if (w_rsp_fire)      state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  // --------------------------------------------------------------------------
  // Datapath and counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= 1'b1;
      id_q       <= 1'b0;
      p0_q       <= '0;
      p_q        <= '0;
      g_q        <= '0;
      cin_q      <= 1'b0;
      k_q        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (w_accept) begin
        id_q      <= w_grant;
        rr_last_q <= w_grant;
        p0_q      <= w_p_init;
        p_q       <= w_p_init;
        g_q       <= w_g_init;
        cin_q     <= w_cin;
        k_q       <= '0;
      end else if (state_q == LVL) begin
        p_q <= w_p_next;
        g_q <= w_g_next;
        k_q <= k_q + 1'b1;
        if (k_q == K_LAST) begin
          // Carry into bit i is the full prefix generate of bits i-1..0.
          sum_q  <= p0_q ^ {w_g_next[W-2:0], cin_q};
          cout_q <= w_g_next[W-1];
        end
      end
      if (w_rsp_fire) begin
        done_cnt_q <= done_cnt_q + 1'b1;
      end
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign done_cnt = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ksa_share_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_ksa_share_sched
// Purpose : Directed self-checking bench for ksa_share_sched. The completion
//           counter is narrowed to 4 bits so its wrap is reached quickly.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ksa_share_sched;

  localparam int W    = 32;
  localparam int CNTW = 4;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [1:0]      req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic            busy;
  logic [CNTW-1:0] done_cnt;

  int checks;
  int errors;
  int exp_cnt;

  ksa_share_sched #(.W(W), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, wait for its grant and accept edge, scramble the
  // operands afterwards, then count edges until rsp_valid. Leaves the
  // response pending. ok = 0 if any bounded wait expires.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output int lat, output bit ok);
    int n;
    ok  = 1'b1;
    lat = 0;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id]      = cin;
    req_valid[id]    = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready[id]) ok = 1'b0;
    @(posedge clk); #1;
    req_valid[id]    = 1'b0;
    req_a[id*W +: W] = ~a;
    req_b[id*W +: W] = a ^ b;
    req_cin[id]      = ~cin;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) ok = 1'b0;
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0)     begin errors++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
    checks++; if (rsp_sum !== 32'h0)   begin errors++; $display("FAIL reset_rsp_sum got %h want 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0)   begin errors++; $display("FAIL reset_rsp_cout got %b want 0", rsp_cout); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done_cnt !== 4'd0)   begin errors++; $display("FAIL reset_done_cnt got %0d want 0", done_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_req0();
    int lat; bit ok;
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, ok);
    checks++; if (!ok)       begin errors++; $display("FAIL req0_timeout got ok=%0d want 1", ok); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL req0_latency got %0d want 5", lat); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL req0_ready_in_resp got %b want 00", req_ready); end
    checks++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 1'b0)
      begin errors++; $display("FAIL req0_result got id=%b sum=%h cout=%b want id=0 sum=00000000 cout=1", rsp_id, rsp_sum, rsp_cout); end
    complete();
    checks++; if (done_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL req0_done_cnt got %0d want %0d", done_cnt, exp_cnt % 16); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req0_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_req1();
    int lat; bit ok;
    issue(1, 32'h7FFF_FFFF, 32'h0, 1'b1, lat, ok);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL req1a_latency got ok=%0d lat=%0d want ok=1 lat=5", ok, lat); end
    checks++; if (rsp_sum !== 32'h8000_0000 || rsp_cout !== 1'b0 || rsp_id !== 1'b1)
      begin errors++; $display("FAIL req1a_result got id=%b sum=%h cout=%b want id=1 sum=80000000 cout=0", rsp_id, rsp_sum, rsp_cout); end
    complete();
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat, ok);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL req1b_latency got ok=%0d lat=%0d want ok=1 lat=5", ok, lat); end
    checks++; if (rsp_sum !== 32'hACF1_3568 || rsp_cout !== 1'b0 || rsp_id !== 1'b1)
      begin errors++; $display("FAIL req1b_result got id=%b sum=%h cout=%b want id=1 sum=acf13568 cout=0", rsp_id, rsp_sum, rsp_cout); end
    complete();
    checks++; if (done_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL req1_done_cnt got %0d want %0d", done_cnt, exp_cnt % 16); end
  endtask

  // Both requesters held valid; last grant was requester 1, so 0 goes first.
  task automatic test_alternate();
    int ngrant; int nrsp; int cyc; bit both_ready;
    logic [3:0] grants; logic [3:0] ids; logic [W-1:0] sums [4];
    ngrant = 0; nrsp = 0; cyc = 0; both_ready = 1'b0; grants = '0; ids = '0;
    req_a = {32'hFFFF_0000, 32'h0000_0001};
    req_b = {32'h0001_0000, 32'h0000_0002};
    req_cin = 2'b10;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    while (nrsp < 4 && cyc < 80) begin
      if (req_ready == 2'b11) both_ready = 1'b1;
      if (req_ready != 2'b00 && ngrant < 4) begin grants[ngrant] = req_ready[1]; ngrant++; end
      if (rsp_valid && nrsp < 4) begin ids[nrsp] = rsp_id; sums[nrsp] = rsp_sum; nrsp++; end
      @(posedge clk); #1; cyc++;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    exp_cnt += 4;
    checks++; if (nrsp !== 4) begin errors++; $display("FAIL alt_timeout got %0d responses want 4", nrsp); end
    checks++; if (both_ready) begin errors++; $display("FAIL alt_both_ready got 11 want one-hot"); end
    checks++; if (grants !== 4'b1010) begin errors++; $display("FAIL alt_grants got %b want 1010 (bit0 first)", grants); end
    checks++; if (ids !== 4'b1010) begin errors++; $display("FAIL alt_ids got %b want 1010 (bit0 first)", ids); end
    checks++; if (sums[0] !== 32'h3 || sums[1] !== 32'h1)
      begin errors++; $display("FAIL alt_sums got %h %h want 00000003 00000001", sums[0], sums[1]); end
    checks++; if (done_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL alt_done_cnt got %0d want %0d", done_cnt, exp_cnt % 16); end
  endtask

  task automatic test_backpressure();
    int lat; bit ok; int bad;
    bad = 0;
    issue(0, 32'h0000_0005, 32'h0000_0007, 1'b1, lat, ok);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL bp_latency got ok=%0d lat=%0d want ok=1 lat=5", ok, lat); end
    req_valid = 2'b10;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'hD || rsp_cout !== 1'b0 || rsp_id !== 1'b0 ||
          req_ready !== 2'b00 || busy !== 1'b1 || done_cnt !== 4'(exp_cnt)) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got v=%b sum=%h id=%b rdy=%b busy=%b cnt=%0d want v=1 sum=0000000d id=0 rdy=00 busy=1 cnt=%0d",
                 i, rsp_valid, rsp_sum, rsp_id, req_ready, busy, done_cnt, exp_cnt % 16);
      end
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) errors++;
    complete();
    req_valid = 2'b00;
    checks++; if (done_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL bp_done_cnt got %0d want %0d", done_cnt, exp_cnt % 16); end
    // Requester 1 was valid on the handshake edge; no same-cycle turnaround.
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_turnaround busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midflight();
    int lat; bit ok; int seen;
    seen = 0;
    req_a[W-1:0] = 32'h1111_1111; req_b[W-1:0] = 32'h2222_2222; req_cin[0] = 1'b0;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== 4'd0)
      begin errors++; $display("FAIL midrst_async got busy=%b v=%b cnt=%0d want 0 0 0", busy, rsp_valid, done_cnt); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_rsp got %0d valid cycles want 0", seen); end
    req_a = {32'hAAAA_AAAA, 32'h0F0F_0F0F};
    req_b = {32'h5555_5555, 32'h0F0F_0F0F};
    req_cin = 2'b01;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b want 01", req_ready); end
    req_valid = 2'b00;
    issue(0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, lat, ok);
    checks++; if (!ok || lat !== 5 || rsp_id !== 1'b0 || rsp_sum !== 32'h1E1E_1E1F || rsp_cout !== 1'b0)
      begin errors++; $display("FAIL midrst_op got ok=%0d lat=%0d id=%b sum=%h cout=%b want 1 5 0 1e1e1e1f 0", ok, lat, rsp_id, rsp_sum, rsp_cout); end
    complete();
    checks++; if (done_cnt !== 4'd1) begin errors++; $display("FAIL midrst_done_cnt got %0d want 1", done_cnt); end
  endtask

  // Back-to-back random operations, alternating requesters, against a
  // 33-bit reference add; the 4-bit counter wraps along the way.
  task automatic test_back_to_back();
    int lat; bit ok; logic [W-1:0] a, b; logic cin; logic [W:0] ref_v; int id;
    bit wrapped;
    wrapped = 1'b0;
    for (int n = 0; n < 24; n++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); id = n % 2;
      if (n == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; end
      ref_v = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      issue(id, a, b, cin, lat, ok);
      checks++;
      if (!ok || lat !== 5 || rsp_id !== 1'(id) || rsp_sum !== ref_v[W-1:0] || rsp_cout !== ref_v[W]) begin
        errors++;
        $display("FAIL b2b_op%0d got ok=%0d lat=%0d id=%b sum=%h cout=%b want 1 5 %0d %h %b",
                 n, ok, lat, rsp_id, rsp_sum, rsp_cout, id, ref_v[W-1:0], ref_v[W]);
      end
      complete();
      if (exp_cnt % 16 == 0) wrapped = 1'b1;
      checks++; if (done_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL b2b_done_cnt%0d got %0d want %0d", n, done_cnt, exp_cnt % 16); end
    end
    checks++; if (!wrapped) begin errors++; $display("FAIL b2b_wrap got no wrap want wrap to 0"); end
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt = 0;
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_cin = 2'b00; rsp_ready = 1'b0;
    test_reset();
    test_req0();
    test_req1();
    test_alternate();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
